// File: rtl/cpu_ctrl_fsm.sv
// cpu_ctrl_fsm: multi-cycle control unit for the 8-bit CPU datapath.
// It fetches a 32-bit word over a req/ack handshake, decodes it, and drives
// the ALU selects and register-file addresses. Each instruction ends with a
// one-cycle reg_we/pc_en pulse.
// Ports: clk, rst (async, active-high), run, imem_req/imem_ack/instr (fetch),
//   ir, alu_op, imm_sel, sub_sel, wr_addr, rd_addr1, rd_addr2, imm (decode),
//   reg_we, pc_en (writeback pulses), err, err_code (sticky error).
// Optional: define CPU_CTRL_PERF_EN to add the retired[15:0] counter port.
module cpu_ctrl_fsm #(
   parameter int unsigned IMEM_TO = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        run,
   output logic        imem_req,
   input  logic        imem_ack,
   input  logic [31:0] instr,
   output logic [31:0] ir,
   output logic [2:0]  alu_op,
   output logic        imm_sel,
   output logic        sub_sel,
   output logic [2:0]  wr_addr,
   output logic [2:0]  rd_addr1,
   output logic [2:0]  rd_addr2,
   output logic [7:0]  imm,
   output logic        reg_we,
   output logic        pc_en,
`ifdef CPU_CTRL_PERF_EN
   output logic [15:0] retired,
`endif
   output logic        err,
   output logic [1:0]  err_code
);

   typedef enum logic [2:0] {
      IDLE, FETCH, DECODE, EXEC, WB, ERR
   } state_t;

   state_t     state;
   logic [7:0] to_cnt;

   // Address fields follow ir directly, so they only move when ir loads.
   assign wr_addr  = ir[18:16];
   assign rd_addr1 = ir[10:8];
   assign rd_addr2 = ir[2:0];
   assign imm      = ir[7:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         to_cnt   <= '0;
         ir       <= '0;
         imem_req <= 1'b0;
         alu_op   <= '0;
         imm_sel  <= 1'b0;
         sub_sel  <= 1'b0;
         reg_we   <= 1'b0;
         pc_en    <= 1'b0;
         err      <= 1'b0;
         err_code <= '0;
`ifdef CPU_CTRL_PERF_EN
         retired  <= '0;
`endif
      end else begin
         reg_we <= 1'b0;
         pc_en  <= 1'b0;
         unique case (state)
            IDLE: begin
               if (run) begin
                  state    <= FETCH;
                  imem_req <= 1'b1;
                  to_cnt   <= '0;
               end
            end
            FETCH: begin
               // to_cnt holds the number of earlier ack-low cycles, so an
               // ack on the IMEM_TO-th cycle still wins over the timeout.
               if (imem_ack) begin
                  ir       <= instr;
                  imem_req <= 1'b0;
                  state    <= DECODE;
               end else if (to_cnt == 8'(IMEM_TO - 1)) begin
                  imem_req <= 1'b0;
                  err      <= 1'b1;
                  err_code <= 2'b10;
                  state    <= ERR;
               end else begin
                  to_cnt <= to_cnt + 8'd1;
               end
            end
            DECODE: begin
               state <= EXEC;
               case (ir[31:24])
                  8'h00: begin
                     alu_op  <= 3'b000;
                     imm_sel <= 1'b1;
                     sub_sel <= 1'b0;
                  end
                  8'h01: begin
                     alu_op  <= 3'b000;
                     imm_sel <= 1'b0;
                     sub_sel <= 1'b0;
                  end
                  8'h02: begin
                     alu_op  <= 3'b001;
                     imm_sel <= 1'b0;
                     sub_sel <= 1'b0;
                  end
                  8'h03: begin
                     alu_op  <= 3'b001;
                     imm_sel <= 1'b0;
                     sub_sel <= 1'b1;
                  end
                  8'h04: begin
                     alu_op  <= 3'b010;
                     imm_sel <= 1'b0;
                     sub_sel <= 1'b0;
                  end
                  8'h05: begin
                     alu_op  <= 3'b011;
                     imm_sel <= 1'b0;
                     sub_sel <= 1'b0;
                  end
                  default: begin
                     err      <= 1'b1;
                     err_code <= 2'b01;
                     state    <= ERR;
                  end
               endcase
            end
            EXEC: begin
               // Pulses are registered, so they are set on the way into WB.
               state  <= WB;
               reg_we <= 1'b1;
               pc_en  <= 1'b1;
            end
            WB: begin
`ifdef CPU_CTRL_PERF_EN
               retired <= retired + 16'd1;
`endif
               if (run) begin
                  state    <= FETCH;
                  imem_req <= 1'b1;
                  to_cnt   <= '0;
               end else begin
                  state <= IDLE;
               end
            end
            ERR: begin
               state    <= ERR;
               imem_req <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// tb_cpu_ctrl_fsm: directed bench for cpu_ctrl_fsm.
// Expected decodes are queued at fetch and popped at the writeback pulse.
module tb_cpu_ctrl_fsm;

   logic        clk = 1'b0;
   logic        rst, run, imem_req, imem_ack;
   logic [31:0] instr, ir;
   logic [2:0]  alu_op, wr_addr, rd_addr1, rd_addr2;
   logic        imm_sel, sub_sel, reg_we, pc_en, err;
   logic [7:0]  imm;
   logic [1:0]  err_code;
`ifdef CPU_CTRL_PERF_EN
   logic [15:0] retired;
`endif

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [31:0] ir;
      logic [2:0]  alu_op;
      logic        imm_sel;
      logic        sub_sel;
      logic [2:0]  wr;
      logic [2:0]  r1;
      logic [2:0]  r2;
      logic [7:0]  imm;
   } exp_t;

   exp_t sb[$];

   cpu_ctrl_fsm #(.IMEM_TO(15)) dut (
      .clk(clk), .rst(rst), .run(run),
      .imem_req(imem_req), .imem_ack(imem_ack), .instr(instr),
      .ir(ir), .alu_op(alu_op), .imm_sel(imm_sel), .sub_sel(sub_sel),
      .wr_addr(wr_addr), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
      .imm(imm), .reg_we(reg_we), .pc_en(pc_en),
`ifdef CPU_CTRL_PERF_EN
      .retired(retired),
`endif
      .err(err), .err_code(err_code)
   );

   always #5 clk = ~clk;

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(logic [31:0] w);
      exp_t e;
      e.ir      = w;
      e.wr      = w[18:16];
      e.r1      = w[10:8];
      e.r2      = w[2:0];
      e.imm     = w[7:0];
      e.imm_sel = (w[31:24] == 8'h00);
      e.sub_sel = (w[31:24] == 8'h03);
      case (w[31:24])
         8'h02, 8'h03: e.alu_op = 3'b001;
         8'h04:        e.alu_op = 3'b010;
         8'h05:        e.alu_op = 3'b011;
         default:      e.alu_op = 3'b000;
      endcase
      return e;
   endfunction

   task automatic wait_req(string tag);
      int n = 0;
      while (!imem_req && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk(tag, imem_req, 1);
   endtask

   // Fetch one word after 'waits' ack-low cycles, then check the writeback.
   task automatic issue(logic [31:0] w, int waits, bit drop, string tag);
      int   lat;
      exp_t e;
      wait_req({tag, "_req"});
      for (int i = 0; i < waits; i++) begin
         chk({tag, "_reqhold"}, imem_req, 1);
         @(negedge clk);
      end
      imem_ack = 1'b1;
      instr    = w;
      sb.push_back(model(w));
      @(negedge clk);
      imem_ack = 1'b0;
      instr    = $urandom;
      lat = 1;
      while (!reg_we && lat < 10) begin
         @(negedge clk);
         lat++;
         if (drop && lat == 2) run = 1'b0;
      end
      chk({tag, "_lat"}, lat, 3);
      chk({tag, "_pc_en"}, pc_en, 1);
      chk({tag, "_sbsize"}, sb.size(), 1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk({tag, "_ir"}, ir, e.ir);
         chk({tag, "_alu_op"}, alu_op, e.alu_op);
         chk({tag, "_imm_sel"}, imm_sel, e.imm_sel);
         chk({tag, "_sub_sel"}, sub_sel, e.sub_sel);
         chk({tag, "_wr"}, wr_addr, e.wr);
         chk({tag, "_rd1"}, rd_addr1, e.r1);
         chk({tag, "_rd2"}, rd_addr2, e.r2);
         chk({tag, "_imm"}, imm, e.imm);
      end
      @(negedge clk);
      chk({tag, "_we_once"}, reg_we, 0);
      chk({tag, "_pc_once"}, pc_en, 0);
   endtask

   initial begin
      rst      = 1'b1;
      run      = 1'b0;
      imem_ack = 1'b0;
      instr    = '0;
      repeat (2) @(negedge clk);
      chk("rst_req", imem_req, 0);
      chk("rst_we", reg_we, 0);
      chk("rst_pc", pc_en, 0);
      chk("rst_err", err, 0);
      chk("rst_code", err_code, 0);
      chk("rst_ir", ir, 0);
      chk("rst_alu", alu_op, 0);
      rst = 1'b0;

      // reset while fetching
      run = 1'b1;
      @(negedge clk);
      chk("t1_fetch", imem_req, 1);
      rst = 1'b1;
      #1;
      chk("t1_req", imem_req, 0);
      chk("t1_we", reg_we, 0);
      chk("t1_pc", pc_en, 0);
      chk("t1_err", err, 0);
      @(negedge clk);
      chk("t1_idle", imem_req, 0);
      rst = 1'b0;

      issue(32'h02030105, 0, 1'b0, "t2");
      issue(32'h03020304, 0, 1'b0, "t3");
      issue(32'h04070102, 3, 1'b0, "and_w3");
      issue(32'h05010203, 14, 1'b0, "or_w14");
      issue(32'h01050600, 0, 1'b0, "mov");
      issue(32'h000400AB, 0, 1'b1, "t4");
      for (int i = 0; i < 5; i++) begin
         chk("t4_noreq", imem_req, 0);
         @(negedge clk);
      end

      // illegal opcode
      run = 1'b1;
      wait_req("t5_req");
      imem_ack = 1'b1;
      instr    = 32'h07000000;
      @(negedge clk);
      imem_ack = 1'b0;
      @(negedge clk);
      chk("t5_err", err, 1);
      chk("t5_code", err_code, 2'b01);
      for (int i = 0; i < 6; i++) begin
         chk("t5_we", reg_we, 0);
         chk("t5_pc", pc_en, 0);
         chk("t5_req_lo", imem_req, 0);
         chk("t5_sticky", err, 1);
         @(negedge clk);
      end

      // fetch timeout
      rst = 1'b1;
      @(negedge clk);
      chk("t5_clr", err, 0);
      rst = 1'b0;
      wait_req("to_req");
      for (int i = 0; i < 15; i++) begin
         chk("to_hold", imem_req, 1);
         @(negedge clk);
      end
      chk("to_err", err, 1);
      chk("to_code", err_code, 2'b10);
      chk("to_req_lo", imem_req, 0);

`ifdef CPU_CTRL_PERF_EN
      rst = 1'b1;
      @(negedge clk);
      chk("perf_rst", retired, 0);
      rst = 1'b0;
      issue(32'h02010203, 0, 1'b0, "p1");
      issue(32'h03010203, 0, 1'b0, "p2");
      issue(32'h04010203, 0, 1'b0, "p3");
      chk("perf_cnt", retired, 3);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
